snake_vga_render: RTL and testbench

SNAKE_VGA_RENDER -- requirements
Module: snake_vga_render

---
 rtl/snake_pkg.sv | 60 ++++++
 rtl/vga_timing.sv | 101 ++++++++++
 rtl/snake_vga_render.sv | 165 ++++++++++++++++
 tb/tb_snake_vga_render.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and helpers for the snake VGA renderer.
// Holds the 640x480@60 timing constants, the default palette, the
// encodings of the mode input and pixel class, and small compare helpers.
// No ports; imported with import snake_pkg::*.
package snake_pkg;

  // Horizontal timing in pixels: active, front porch, sync, back porch.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Default palette, {R4,G4,B4}.
  localparam logic [11:0] COL_HEAD  = 12'h0F0;
  localparam logic [11:0] COL_BODY  = 12'h0A0;
  localparam logic [11:0] COL_OVER  = 12'h400;
  localparam logic [11:0] COL_BLACK = 12'h000;

  // 2'b11 is an alias of run.
  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_PAUSE   = 2'b01,
    MODE_OVER    = 2'b10,
    MODE_RUN_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    PIX_BG   = 2'd0,
    PIX_BODY = 2'd1,
    PIX_HEAD = 2'd2
  } pix_class_e;

  // Inclusive unsigned range test; lo > hi never matches.
  function automatic logic in_span(input logic [9:0] lo, input logic [9:0] hi,
                                   input logic [9:0] x);
    return (x >= lo) && (x <= hi);
  endfunction

  function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a : b;
  endfunction

  // Halve each 4-bit channel independently (paused dimming).
  function automatic logic [11:0] dim_colour(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// A free-running divider produces pix_tick every CLK_PER_PIX clocks; the
// horizontal/vertical counters only move on pix_tick. Sync and visible
// decodes are combinational from the counters so the parent can register
// them alongside its colour. The geometry parameters default to the
// standard 640x480 numbers and exist so the raster can be shrunk.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   pix_tick      one-clk strobe, the pixel-advance enable
//   h_cnt, v_cnt  current pixel column/row
//   visible       h_cnt/v_cnt inside the active area
//   hsync_act     h_cnt inside the horizontal sync pulse (active high)
//   vsync_act     v_cnt inside the vertical sync pulse (active high)
//   frame_wrap    combinational: this pix_tick moves the raster to (0,0)
//   frame_start   registered one-clk pulse following frame_wrap
module vga_timing
  import snake_pkg::*;
#(
  parameter int CLK_PER_PIX = 4,
  parameter int HA = H_ACTIVE,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VA = V_ACTIVE,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       visible,
  output logic       hsync_act,
  output logic       vsync_act,
  output logic       frame_wrap,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_PIX - 1);

  localparam logic [9:0] H_LAST   = 10'(HA + HF + HS + HB - 1);
  localparam logic [9:0] V_LAST   = 10'(VA + VF + VS + VB - 1);
  localparam logic [9:0] H_VIS    = 10'(HA);
  localparam logic [9:0] V_VIS    = 10'(VA);
  localparam logic [9:0] HS_FIRST = 10'(HA + HF);
  localparam logic [9:0] HS_LAST  = 10'(HA + HF + HS - 1);
  localparam logic [9:0] VS_FIRST = 10'(VA + VF);
  localparam logic [9:0] VS_LAST  = 10'(VA + VF + VS - 1);

  logic [DIV_W-1:0] div;

  // With CLK_PER_PIX == 1 the divider sits at 0 and pix_tick is always high.
  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign frame_wrap = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_act  = in_span(HS_FIRST, HS_LAST, h_cnt);
  assign vsync_act  = in_span(VS_FIRST, VS_LAST, v_cnt);

  // Reset leaves the raster at (0,0) without a pulse; the first pulse
  // comes at the end of frame 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: rtl/snake_vga_render.sv
// Snake game VGA renderer.
// Draws a head box and a body made of the tail box plus the bounding
// rectangle of head and tail. Box coordinates are captured into shadow
// registers at the frame wrap so a frame is always drawn from one
// consistent snapshot. hsync, vsync and rgb are registered together on
// pix_tick, one pixel tick behind the raster counters.
// Ports:
//   clk, rst_n                         system clock, async active-low reset
//   frontHigh/Low/Left/Right [9:0]     head box, rows top/bottom, cols l/r
//   endHigh/Low/Left/Right   [9:0]     tail box, same encoding
//   mode [1:0]                         00 run, 01 paused, 10 game over
//   hsync, vsync                       active-low syncs
//   rgb [11:0]                         {R4,G4,B4}, zero outside active area
//   frame_start                        one-clk pulse at each frame start
module snake_vga_render
  import snake_pkg::*;
#(
  parameter int          CLK_PER_PIX = 4,
  parameter logic [11:0] C_HEAD      = COL_HEAD,
  parameter logic [11:0] C_BODY      = COL_BODY,
  parameter logic [11:0] C_OVER      = COL_OVER,
  // Raster geometry, normally left at the 640x480 defaults.
  parameter int          HA          = H_ACTIVE,
  parameter int          HF          = H_FP,
  parameter int          HS          = H_SYNC,
  parameter int          HB          = H_BP,
  parameter int          VA          = V_ACTIVE,
  parameter int          VF          = V_FP,
  parameter int          VS          = V_SYNC,
  parameter int          VB          = V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  frontHigh,
  input  logic [9:0]  frontLow,
  input  logic [9:0]  frontLeft,
  input  logic [9:0]  frontRight,
  input  logic [9:0]  endHigh,
  input  logic [9:0]  endLow,
  input  logic [9:0]  endLeft,
  input  logic [9:0]  endRight,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       visible;
  logic       hsync_act;
  logic       vsync_act;
  logic       frame_wrap;

  vga_timing #(
    .CLK_PER_PIX (CLK_PER_PIX),
    .HA          (HA),
    .HF          (HF),
    .HS          (HS),
    .HB          (HB),
    .VA          (VA),
    .VF          (VF),
    .VS          (VS),
    .VB          (VB)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_tick    (pix_tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .visible     (visible),
    .hsync_act   (hsync_act),
    .vsync_act   (vsync_act),
    .frame_wrap  (frame_wrap),
    .frame_start (frame_start)
  );

  // Shadow copies of the box inputs, refreshed only at the frame wrap.
  logic [9:0] sh_front_high, sh_front_low, sh_front_left, sh_front_right;
  logic [9:0] sh_end_high,   sh_end_low,   sh_end_left,   sh_end_right;

  // Reset value is High > Low for both boxes, so nothing draws until the
  // first real snapshot is taken at the end of frame 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_front_high  <= 10'h3FF;
      sh_front_low   <= 10'h000;
      sh_front_left  <= 10'h000;
      sh_front_right <= 10'h000;
      sh_end_high    <= 10'h3FF;
      sh_end_low     <= 10'h000;
      sh_end_left    <= 10'h000;
      sh_end_right   <= 10'h000;
    end else if (frame_wrap) begin
      sh_front_high  <= frontHigh;
      sh_front_low   <= frontLow;
      sh_front_left  <= frontLeft;
      sh_front_right <= frontRight;
      sh_end_high    <= endHigh;
      sh_end_low     <= endLow;
      sh_end_left    <= endLeft;
      sh_end_right   <= endRight;
    end
  end

  // Pixel classification.
  logic       head_ok, tail_ok;
  logic       in_head, in_tail, in_bbox;
  logic [9:0] bb_top, bb_bot, bb_left, bb_right;
  pix_class_e pix_class;

  always_comb begin
    head_ok  = (sh_front_high <= sh_front_low) && (sh_front_left <= sh_front_right);
    tail_ok  = (sh_end_high <= sh_end_low) && (sh_end_left <= sh_end_right);
    bb_top   = min10(sh_front_high, sh_end_high);
    bb_bot   = max10(sh_front_low, sh_end_low);
    bb_left  = min10(sh_front_left, sh_end_left);
    bb_right = max10(sh_front_right, sh_end_right);
    in_head  = in_span(sh_front_high, sh_front_low, v_cnt) &&
               in_span(sh_front_left, sh_front_right, h_cnt);
    in_tail  = in_span(sh_end_high, sh_end_low, v_cnt) &&
               in_span(sh_end_left, sh_end_right, h_cnt);
    // The joining rectangle only exists when both ends are real boxes;
    // the tail box itself still draws on its own.
    in_bbox  = head_ok && tail_ok &&
               in_span(bb_top, bb_bot, v_cnt) && in_span(bb_left, bb_right, h_cnt);
    pix_class = PIX_BG;
    if (in_tail || in_bbox) pix_class = PIX_BODY;
    if (in_head)            pix_class = PIX_HEAD;
  end

  // Colour selection; mode is sampled live every pixel.
  mode_e       mode_q;
  logic [11:0] colour;
  logic [11:0] rgb_next;

  assign mode_q = mode_e'(mode);

  always_comb begin
    colour = COL_BLACK;
    case (pix_class)
      PIX_HEAD: colour = C_HEAD;
      PIX_BODY: colour = C_BODY;
      default:  colour = (mode_q == MODE_OVER) ? C_OVER : COL_BLACK;
    endcase
    if (mode_q == MODE_PAUSE) colour = dim_colour(colour);
    rgb_next = visible ? colour : COL_BLACK;
  end

  // Syncs and colour share one register stage so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (pix_tick) begin
      hsync <= ~hsync_act;
      vsync <= ~vsync_act;
      rgb   <= rgb_next;
    end
  end

endmodule

// File: tb/tb_snake_vga_render.sv
// Bench for snake_vga_render on a shrunken raster (64x39 pixels total,
// 48x32 visible) so several whole frames fit in a short run. A reference
// image of each frame is painted from the box snapshot at every frame wrap,
// and every pixel tick is compared against it.
module tb_snake_vga_render;

  localparam int CPP = 4;
  localparam int HA = 48, HF = 4, HS = 8, HB = 4;
  localparam int VA = 32, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FP = HT * VT;
  localparam int RGB_HEAD = 'h0F0, RGB_BODY = 'h0A0, RGB_OVER = 'h400;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  front_high, front_low, front_left, front_right;
  logic [9:0]  end_high, end_low, end_left, end_right;
  logic [1:0]  mode;
  logic        hsync, vsync, frame_start;
  logic [11:0] rgb;

  snake_vga_render #(
    .CLK_PER_PIX (CPP),
    .HA (HA), .HF (HF), .HS (HS), .HB (HB),
    .VA (VA), .VF (VF), .VS (VS), .VB (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frontHigh   (front_high),
    .frontLow    (front_low),
    .frontLeft   (front_left),
    .frontRight  (front_right),
    .endHigh     (end_high),
    .endLow      (end_low),
    .endLeft     (end_left),
    .endRight    (end_right),
    .mode        (mode),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  // Scoreboard state
  int   n_tests = 0;
  int   n_fail  = 0;
  int   clk_n;
  int   img [VT][HT];
  int   sh_fh, sh_fl, sh_fl_c, sh_fr_c, sh_eh, sh_el, sh_el_c, sh_er_c;
  int   hs_fall_n, fs_n;
  int   hs_fall_t [2];
  int   fs_t [2];
  logic prev_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Paint the reference frame: background, joining rectangle, tail, head.
  function automatic void paint();
    bit head_ok, tail_ok;
    head_ok = (sh_fh <= sh_fl) && (sh_fl_c <= sh_fr_c);
    tail_ok = (sh_eh <= sh_el) && (sh_el_c <= sh_er_c);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        img[v][h] = 0;
        if (head_ok && tail_ok &&
            v >= imin(sh_fh, sh_eh) && v <= imax(sh_fl, sh_el) &&
            h >= imin(sh_fl_c, sh_el_c) && h <= imax(sh_fr_c, sh_er_c))
          img[v][h] = 1;
        if (v >= sh_eh && v <= sh_el && h >= sh_el_c && h <= sh_er_c) img[v][h] = 1;
        if (v >= sh_fh && v <= sh_fl && h >= sh_fl_c && h <= sh_fr_c) img[v][h] = 2;
      end
    end
  endfunction

  function automatic int exp_colour(input int cls, input int m);
    int c, r, g, b;
    if (cls == 2)      c = RGB_HEAD;
    else if (cls == 1) c = RGB_BODY;
    else if (m == 2)   c = RGB_OVER;
    else               c = 0;
    if (m == 1) begin
      r = (c / 256) % 16;
      g = (c / 16) % 16;
      b = c % 16;
      c = (r / 2) * 256 + (g / 2) * 16 + (b / 2);
    end
    return c;
  endfunction

  function automatic int rand_coord();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(512, 1023));
    return int'($urandom_range(0, 70));
  endfunction

  // Tick index after which pixel (h,v) of frame f is on the outputs.
  function automatic int k_at(input int f, input int v, input int h);
    return f * FP + v * HT + h + 1;
  endfunction

  // Driver tasks
  task automatic set_boxes(input int fh, input int fl, input int flc, input int frc,
                           input int eh, input int el, input int elc, input int erc);
    front_high = 10'(fh); front_low = 10'(fl); front_left = 10'(flc); front_right = 10'(frc);
    end_high   = 10'(eh); end_low   = 10'(el); end_left   = 10'(elc); end_right   = 10'(erc);
  endtask

  task automatic random_boxes();
    set_boxes(rand_coord(), rand_coord(), rand_coord(), rand_coord(),
              rand_coord(), rand_coord(), rand_coord(), rand_coord());
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    clk_n = 0;
    hs_fall_n = 0;
    fs_n = 0;
    hs_fall_t[0] = 0; hs_fall_t[1] = 0;
    fs_t[0] = 0; fs_t[1] = 0;
    prev_hs = 1'b1;
    sh_fh = 1023; sh_fl = 0; sh_fl_c = 0; sh_fr_c = 0;
    sh_eh = 1023; sh_el = 0; sh_el_c = 0; sh_er_c = 0;
    paint();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hsync"}, 32'(hsync), 32'd1);
    check({tag, " vsync"}, 32'(vsync), 32'd1);
    check({tag, " rgb"}, 32'(rgb), 32'd0);
    check({tag, " frame_start"}, 32'(frame_start), 32'd0);
  endtask

  // One system clock with the reference model checks.
  task automatic step_clk(input bit rand_mode);
    int k, p, h, v, exp_rgb;
    bit vis, exp_hs, exp_vs, wrap;
    @(posedge clk);
    #1;
    clk_n++;
    if (prev_hs === 1'b1 && hsync === 1'b0) begin
      if (hs_fall_n < 2) hs_fall_t[hs_fall_n] = clk_n;
      hs_fall_n++;
    end
    prev_hs = hsync;
    if (frame_start === 1'b1) begin
      if (fs_n < 2) fs_t[fs_n] = clk_n;
      fs_n++;
    end
    if (clk_n % CPP == 0) begin
      k = clk_n / CPP;
      p = (k - 1) % FP;
      h = p % HT;
      v = p / HT;
      vis = (h < HA) && (v < VA);
      exp_rgb = vis ? exp_colour(img[v][h], int'(mode)) : 0;
      exp_hs = !(h >= HA + HF && h < HA + HF + HS);
      exp_vs = !(v >= VA + VF && v < VA + VF + VS);
      wrap = (k % FP == 0);
      check($sformatf("rgb h=%0d v=%0d mode=%0d", h, v, mode), 32'(rgb), 32'(exp_rgb));
      check($sformatf("hsync h=%0d v=%0d", h, v), 32'(hsync), 32'(exp_hs));
      check($sformatf("vsync h=%0d v=%0d", h, v), 32'(vsync), 32'(exp_vs));
      check($sformatf("frame_start tick=%0d", k), 32'(frame_start), 32'(wrap));
      if (wrap) begin
        sh_fh = int'(front_high); sh_fl = int'(front_low);
        sh_fl_c = int'(front_left); sh_fr_c = int'(front_right);
        sh_eh = int'(end_high); sh_el = int'(end_low);
        sh_el_c = int'(end_left); sh_er_c = int'(end_right);
        paint();
      end
      if (rand_mode && $urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
    end else begin
      check($sformatf("frame_start clk=%0d", clk_n), 32'(frame_start), 32'd0);
    end
  endtask

  task automatic run_to(input int k_target, input bit rand_mode);
    while (clk_n / CPP < k_target) step_clk(rand_mode);
  endtask

  // Directed sequence
  initial begin
    set_boxes(10, 14, 20, 24, 10, 14, 2, 6);
    mode = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Frame 0 is blank whatever the inputs; mode still colours background.
    run_to(k_at(0, 3, 0), 1'b0);
    run_to(k_at(0, VT - 1, 0), 1'b1);
    mode = 2'b00;
    check("hsync first fall clk", 32'(hs_fall_t[0]), 32'((HA + HF + 1) * CPP));
    check("line period clk", 32'(hs_fall_t[1] - hs_fall_t[0]), 32'(HT * CPP));

    // Frame 1: head, tail and joining body in run mode; move head mid-frame.
    run_to(k_at(1, 16, 0), 1'b0);
    front_left = 10'd30;
    front_right = 10'd34;
    run_to(k_at(1, VT - 1, 0), 1'b1);

    // Frame 2: moved head; paused rows then game-over rows.
    mode = 2'b01;
    run_to(k_at(2, 13, 0), 1'b0);
    mode = 2'b10;
    run_to(k_at(2, 20, 0), 1'b0);
    check("frame_start first clk", 32'(fs_t[0]), 32'(FP * CPP));
    check("frame period clk", 32'(fs_t[1] - fs_t[0]), 32'(FP * CPP));
    // Inverted head box: no head, no joining body, tail alone remains.
    set_boxes(20, 18, 10, 12, 5, 9, 40, 44);
    run_to(k_at(2, VT - 1, 0), 1'b1);

    // Frame 3: tail only; then random boxes for frame 4.
    mode = 2'b00;
    run_to(k_at(3, 16, 0), 1'b0);
    random_boxes();
    run_to(k_at(4, 20, HA + HF + 2), 1'b1);
    check("frame_start count", 32'(fs_n), 32'd4);

    // Mid-frame reset during an hsync pulse.
    check("hsync low before reset", 32'(hsync), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset held");
    mode = 2'b00;
    release_reset();
    run_to(k_at(0, 3, 0), 1'b1);
    check("hsync fall after re-reset", 32'(hs_fall_t[0]), 32'((HA + HF + 1) * CPP));
    check("no frame_start in partial frame", 32'(fs_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
